// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: evaluates the conditional-branch funct3 set, checks
// the fetch prediction and holds the redirect in a one-entry valid/ready output register.
// Optional performance counters are built only when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_illegal
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredict
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q;
    logic            taken_q;
    logic            mispredict_q;
    logic            illegal_q;
    logic [XLEN-1:0] redirect_q;

    logic            taken_d;
    logic            mispredict_d;
    logic            illegal_d;
    logic [XLEN-1:0] redirect_d;
    logic            accept;

    assign out_valid       = (state_q == FULL);
    assign in_ready        = ~out_valid | out_ready;
    assign accept          = in_valid & in_ready;
    assign out_taken       = taken_q;
    assign out_mispredict  = mispredict_q;
    assign out_illegal     = illegal_q;
    assign out_redirect_pc = redirect_q;

    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (in_funct3)
            3'b000:  taken_d = (in_src1 == in_src2);
            3'b001:  taken_d = (in_src1 != in_src2);
            3'b100:  taken_d = ($signed(in_src1) <  $signed(in_src2));
            3'b101:  taken_d = ($signed(in_src1) >= $signed(in_src2));
            3'b110:  taken_d = (in_src1 <  in_src2);
            3'b111:  taken_d = (in_src1 >= in_src2);
            default: illegal_d = 1'b1;
        endcase
        // Illegal ops resolve not-taken, so a taken prediction reads as a mispredict.
        mispredict_d = taken_d ^ in_pred_taken;
        redirect_d   = taken_d ? (in_pc + in_imm) : (in_pc + XLEN'(4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            redirect_q   <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        taken_q      <= taken_d;
                        mispredict_q <= mispredict_d;
                        illegal_q    <= illegal_d;
                        redirect_q   <= redirect_d;
                        state_q      <= FULL;
                    end
                end
                FULL: begin
                    if (accept) begin
                        taken_q      <= taken_d;
                        mispredict_q <= mispredict_d;
                        illegal_q    <= illegal_d;
                        redirect_q   <= redirect_d;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] perf_branches_q;
    logic [CNT_W-1:0] perf_mispredict_q;

    assign perf_branches   = perf_branches_q;
    assign perf_mispredict = perf_mispredict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q   <= '0;
            perf_mispredict_q <= '0;
        end else if (accept && !flush) begin
            if (perf_branches_q != '1) begin
                perf_branches_q <= perf_branches_q + CNT_W'(1);
            end
            if (mispredict_d && (perf_mispredict_q != '1)) begin
                perf_mispredict_q <= perf_mispredict_q + CNT_W'(1);
            end
        end
    end
`else
    if (CNT_W == 0) begin : g_cnt_w_zero
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit (XLEN=32, CNT_W=4); perf checks run
// only when BRU_PERF_CNT_EN is defined.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;
    logic            out_illegal;
`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispredict;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_funct3       (in_funct3),
        .in_src1         (in_src1),
        .in_src2         (in_src2),
        .in_pc           (in_pc),
        .in_imm          (in_imm),
        .in_pred_taken   (in_pred_taken),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_mispredict  (out_mispredict),
        .out_redirect_pc (out_redirect_pc),
        .out_illegal     (out_illegal)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches   (perf_branches),
        .perf_mispredict (perf_mispredict)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        in_valid      = 1'b1;
        in_funct3     = f3;
        in_src1       = s1;
        in_src2       = s2;
        in_pc         = pc;
        in_imm        = imm;
        in_pred_taken = pred;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic tk, input logic mp,
                           input logic il, input logic [31:0] rpc);
        chk({tag, ".valid"},    64'(out_valid),       64'(v));
        chk({tag, ".taken"},    64'(out_taken),       64'(tk));
        chk({tag, ".mispred"},  64'(out_mispredict),  64'(mp));
        chk({tag, ".illegal"},  64'(out_illegal),     64'(il));
        chk({tag, ".redirect"}, 64'(out_redirect_pc), 64'(rpc));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_funct3 = 3'b000; in_src1 = '0; in_src2 = '0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0;
        step(); step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
`ifdef BRU_PERF_CNT_EN
        chk("reset.perf_br", 64'(perf_branches), 64'd0);
`endif
        rst = 1'b0;

        // T1/T2: back-to-back ops with out_ready held high
        drive_op(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        step(); chk_out("t1_blt", 1'b1, 1'b1, 1'b1, 1'b0, 32'h120);
        drive_op(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        step(); chk_out("t2_bltu", 1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
        drive_op(3'b111, 32'h5, 32'h5, 32'h200, 32'h40, 1'b1);
        step(); chk_out("t2_bgeu", 1'b1, 1'b1, 1'b0, 1'b0, 32'h240);
        drive_op(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b0);
        step(); chk_out("bge_neg", 1'b1, 1'b0, 1'b0, 1'b0, 32'h204);
        drive_op(3'b001, 32'h3, 32'h3, 32'h300, 32'hFFFF_FFF0, 1'b1);
        step(); chk_out("bne_eq", 1'b1, 1'b0, 1'b1, 1'b0, 32'h304);

        in_valid = 1'b0;
        step(); chk("drain.valid", 64'(out_valid), 64'd0);

        // T3: backpressure
        out_ready = 1'b0;
        drive_op(3'b000, 32'h7, 32'h7, 32'h300, 32'h10, 1'b0);
        step(); chk_out("t3_a", 1'b1, 1'b1, 1'b1, 1'b0, 32'h310);
        drive_op(3'b001, 32'h1, 32'h2, 32'h400, 32'h8, 1'b1);
        #1 chk("t3_stall.in_ready", 64'(in_ready), 64'd0);
        step(); chk_out("t3_a_held", 1'b1, 1'b1, 1'b1, 1'b0, 32'h310);
        out_ready = 1'b1;
        #1 chk("t3_release.in_ready", 64'(in_ready), 64'd1);
        step(); chk_out("t3_b", 1'b1, 1'b1, 1'b0, 1'b0, 32'h408);
        in_valid = 1'b0;
        step(); chk("t3_drain.valid", 64'(out_valid), 64'd0);

        // T4: flush while FULL with a new op offered
        out_ready = 1'b0;
        drive_op(3'b000, 32'h1, 32'h2, 32'h500, 32'h10, 1'b0);
        step(); chk_out("t4_d", 1'b1, 1'b0, 1'b0, 1'b0, 32'h504);
        flush = 1'b1;
        drive_op(3'b000, 32'h9, 32'h9, 32'h600, 32'h10, 1'b1);
        step(); chk("t4_flush.valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        step(); chk("t4_after.valid", 64'(out_valid), 64'd0);
`ifdef BRU_PERF_CNT_EN
        chk("t4.perf_br",  64'(perf_branches),   64'd8);
        chk("t4.perf_mis", 64'(perf_mispredict), 64'd3);
`endif

        // T5: PC wrap and illegal funct3
        out_ready = 1'b1;
        drive_op(3'b000, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b0);
        step(); chk_out("t5_wrap", 1'b1, 1'b1, 1'b1, 1'b0, 32'h4);
        drive_op(3'b010, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1);
        step(); chk_out("t5_ill010", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        drive_op(3'b011, 32'h1, 32'h2, 32'h600, 32'h8, 1'b0);
        step(); chk_out("t5_ill011", 1'b1, 1'b0, 1'b0, 1'b1, 32'h604);

        // T6: reset while FULL and held
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step(); chk("t6_held.valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step(); chk_out("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
`ifdef BRU_PERF_CNT_EN
        chk("t6.perf_br0", 64'(perf_branches), 64'd0);
        out_ready = 1'b1;
        drive_op(3'b000, 32'h1, 32'h1, 32'h700, 32'h10, 1'b0);
        for (int i = 0; i < 20; i++) step();
        in_valid = 1'b0;
        step();
        chk("t6.perf_br_sat",  64'(perf_branches),   64'd15);
        chk("t6.perf_mis_sat", 64'(perf_mispredict), 64'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
